// File: rtl/mx_commutator_reg_if.sv
// Bus bundle for mx_commutator_reg: raw bit beat, select configuration and lane outputs.
// The master side drives beats and configuration; the slave side is the commutator.
interface mx_commutator_reg_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 3,
    parameter int SEL_W = $clog2(N_IN),
    parameter int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
);
    logic [N_IN-1:0]  d;
    logic             d_valid;
    logic             rot_en;
    logic             cfg_wr;
    logic [IDX_W-1:0] cfg_idx;
    logic [SEL_W-1:0] cfg_sel;
    logic             cfg_commit;
    logic             cfg_busy;
    logic [N_OUT-1:0] out;
    logic             out_valid;
    logic             err;

    modport master (
        output d, d_valid, rot_en, cfg_wr, cfg_idx, cfg_sel, cfg_commit,
        input  cfg_busy, out, out_valid, err
    );

    modport slave (
        input  d, d_valid, rot_en, cfg_wr, cfg_idx, cfg_sel, cfg_commit,
        output cfg_busy, out, out_valid, err
    );
endinterface

// File: rtl/mx_commutator_reg.sv
// Registered N_IN-to-N_OUT bit commutator with shadow select bank swapped in at stream gaps
// and an optional per-beat auto-rotate of the active selects.
module mx_commutator_reg #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 3,
    parameter int SEL_W = $clog2(N_IN),
    parameter int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    mx_commutator_reg_if.slave        bus
);
    localparam int unsigned NI = N_IN;
    localparam int unsigned NO = N_OUT;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_IN - 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] active [N_OUT];
    logic [SEL_W-1:0] shadow [N_OUT];
    logic [N_OUT-1:0] out_q;
    logic             out_valid_q;
    logic             err_q;

    logic wr_acc, wr_ok, swap, rot;

    always_comb begin
        wr_acc = bus.cfg_wr && (state == IDLE);
        wr_ok  = (32'(bus.cfg_sel) < NI) && (32'(bus.cfg_idx) < NO);
        swap   = (state == PEND) && !bus.d_valid;
        rot    = bus.d_valid && bus.rot_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cfg_commit) state_nxt = PEND;
            PEND:    if (!bus.d_valid)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Swap needs a gap and rotate needs a beat, so the two branches are exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NO; k++) begin
                active[k] <= SEL_W'(k % NI);
                shadow[k] <= SEL_W'(k % NI);
            end
        end else begin
            for (int unsigned k = 0; k < NO; k++) begin
                if (wr_acc && wr_ok && (32'(bus.cfg_idx) == k))
                    shadow[k] <= bus.cfg_sel;
                if (swap)
                    active[k] <= shadow[k];
                else if (rot)
                    active[k] <= (active[k] == SEL_MAX) ? '0 : active[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= bus.d_valid;
            if (bus.d_valid) begin
                for (int unsigned k = 0; k < NO; k++)
                    out_q[k] <= bus.d[active[k]];
            end
            if (wr_acc && !wr_ok)
                err_q <= 1'b1;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.cfg_busy  = (state == PEND);
endmodule
